// File: rtl/display_pkg.sv
// Shared 7-segment definitions: glyph patterns (abcdefg, a = MSB) and bus bit positions.
package display_pkg;

    localparam logic [6:0] GLYPH_0 = 7'b1111110;
    localparam logic [6:0] GLYPH_1 = 7'b0110000;
    localparam logic [6:0] GLYPH_2 = 7'b1101101;
    localparam logic [6:0] GLYPH_3 = 7'b1111001;
    localparam logic [6:0] GLYPH_4 = 7'b0110011;
    localparam logic [6:0] GLYPH_5 = 7'b1011011;
    localparam logic [6:0] GLYPH_6 = 7'b1011111;
    localparam logic [6:0] GLYPH_7 = 7'b1110000;
    localparam logic [6:0] GLYPH_8 = 7'b1111111;
    localparam logic [6:0] GLYPH_9 = 7'b1111011;
    localparam logic [6:0] GLYPH_A = 7'b1110111;
    localparam logic [6:0] GLYPH_B = 7'b0011111;
    localparam logic [6:0] GLYPH_C = 7'b1001110;
    localparam logic [6:0] GLYPH_D = 7'b0111101;
    localparam logic [6:0] GLYPH_E = 7'b1001111;
    localparam logic [6:0] GLYPH_F = 7'b1000111;

    // Bit positions inside the 8-bit segments bus {a,b,c,d,e,f,g,dp}
    localparam int SEG_A  = 7;
    localparam int SEG_B  = 6;
    localparam int SEG_C  = 5;
    localparam int SEG_D  = 4;
    localparam int SEG_E  = 3;
    localparam int SEG_F  = 2;
    localparam int SEG_G  = 1;
    localparam int SEG_DP = 0;

endpackage

// File: rtl/segs72hex.sv
// Combinational inverse of the display driver's encoder: 7-segment glyph to hex nibble.
module segs72hex
    import display_pkg::*;
(
    input  logic [6:0] segs,
    output logic [3:0] hex,
    output logic       is_a2f,
    output logic       invalid
);

    always_comb begin
        hex     = 4'h0;
        invalid = 1'b0;
        case (segs)
            GLYPH_0: hex = 4'h0;
            GLYPH_1: hex = 4'h1;
            GLYPH_2: hex = 4'h2;
            GLYPH_3: hex = 4'h3;
            GLYPH_4: hex = 4'h4;
            GLYPH_5: hex = 4'h5;
            GLYPH_6: hex = 4'h6;
            GLYPH_7: hex = 4'h7;
            GLYPH_8: hex = 4'h8;
            GLYPH_9: hex = 4'h9;
            GLYPH_A: hex = 4'hA;
            GLYPH_B: hex = 4'hB;
            GLYPH_C: hex = 4'hC;
            GLYPH_D: hex = 4'hD;
            GLYPH_E: hex = 4'hE;
            GLYPH_F: hex = 4'hF;
            default: invalid = 1'b1;
        endcase
        is_a2f = !invalid && (hex >= 4'hA);
    end

endmodule

// File: rtl/display_capture.sv
// Samples a multiplexed 4-digit 7-segment bus, debounces each strobe and rebuilds
// the displayed hex value, decimal points and per-digit status.
module display_capture
    import display_pkg::*;
#(
    parameter int STABLE_CYCLES = 4,
    parameter int STALE_W       = 16
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        en,
    input  logic [7:0]  segments,
    input  logic [3:0]  digits,
    output logic [15:0] hexx,
    output logic [3:0]  points,
    output logic [3:0]  is_a2f,
    output logic [3:0]  invalid,
    output logic [3:0]  digit_valid,
    output logic        frame_done,
    output logic        stale
);

    localparam logic [3:0]         STABLE_LAST = 4'(STABLE_CYCLES - 1);
    localparam logic [STALE_W-1:0] STALE_MAX   = '1;

    logic [11:0]        sample_q;
    logic [3:0]         stable_cnt;
    logic [3:0]         stable_next;
    logic               commit_q;
    logic               commit_arm;
    logic               commit;
    logic [3:0]         seen;
    logic [3:0]         seen_next;
    logic [STALE_W-1:0] stale_cnt;
    logic [3:0]         dec_hex;
    logic               dec_a2f;
    logic               dec_invalid;

    // stable_next counts repeat edges of the pattern (0 on its first edge), so a commit
    // is armed exactly once, on the edge where the pattern has been seen STABLE_CYCLES times.
    always_comb begin
        stable_next = 4'd0;
        if (en && $onehot(digits) && ({digits, segments} == sample_q)) begin
            stable_next = (stable_cnt == 4'hF) ? 4'hF : stable_cnt + 4'd1;
        end
        commit_arm = en && $onehot(digits) && (stable_next == STABLE_LAST);
        commit     = commit_q && en;
        seen_next  = seen | sample_q[11:8];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sample_q   <= '0;
            stable_cnt <= '0;
            commit_q   <= 1'b0;
        end else begin
            sample_q   <= {digits, segments};
            stable_cnt <= stable_next;
            commit_q   <= commit_arm;
        end
    end

    segs72hex u_decode (
        .segs    (sample_q[7:1]),
        .hex     (dec_hex),
        .is_a2f  (dec_a2f),
        .invalid (dec_invalid)
    );

    // The commit acts on the pattern still held in sample_q; a commit outranks the stale event.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hexx        <= '0;
            points      <= '0;
            is_a2f      <= '0;
            invalid     <= '0;
            digit_valid <= '0;
            frame_done  <= 1'b0;
            stale       <= 1'b0;
            seen        <= '0;
            stale_cnt   <= '0;
        end else begin
            frame_done <= 1'b0;
            if (commit) begin
                for (int i = 0; i < 4; i++) begin
                    if (sample_q[8+i]) begin
                        hexx[4*i +: 4] <= dec_hex;
                        points[i]      <= sample_q[SEG_DP];
                        is_a2f[i]      <= dec_a2f;
                        invalid[i]     <= dec_invalid;
                        digit_valid[i] <= 1'b1;
                    end
                end
                stale     <= 1'b0;
                stale_cnt <= '0;
                if (seen_next == 4'hF) begin
                    frame_done <= 1'b1;
                    seen       <= '0;
                end else begin
                    seen <= seen_next;
                end
            end else if (!en) begin
                stale_cnt <= '0;
            end else if (stale_cnt != STALE_MAX) begin
                stale_cnt <= stale_cnt + 1'b1;
                if (stale_cnt == STALE_MAX - 1'b1) begin
                    stale       <= 1'b1;
                    digit_valid <= '0;
                    seen        <= '0;
                end
            end
        end
    end

endmodule

// File: tb/tb_display_capture.sv
// Directed self-checking bench for display_capture (main instance STABLE_CYCLES=4,
// STALE_W=4; a second instance with STABLE_CYCLES=1 shares the same bus).
module tb_display_capture;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  segments;
    logic [3:0]  digits;

    logic [15:0] hexx;
    logic [3:0]  points, is_a2f, invalid, digit_valid;
    logic        frame_done, stale;

    logic [15:0] hexx1;
    logic [3:0]  points1, is_a2f1, invalid1, digit_valid1;
    logic        frame_done1, stale1;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    display_capture #(.STABLE_CYCLES(4), .STALE_W(4)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .segments    (segments),
        .digits      (digits),
        .hexx        (hexx),
        .points      (points),
        .is_a2f      (is_a2f),
        .invalid     (invalid),
        .digit_valid (digit_valid),
        .frame_done  (frame_done),
        .stale       (stale)
    );

    display_capture #(.STABLE_CYCLES(1), .STALE_W(16)) dut1 (
        .clk         (clk),
        .rst_n       (rst_n),
        .en          (en),
        .segments    (segments),
        .digits      (digits),
        .hexx        (hexx1),
        .points      (points1),
        .is_a2f      (is_a2f1),
        .invalid     (invalid1),
        .digit_valid (digit_valid1),
        .frame_done  (frame_done1),
        .stale       (stale1)
    );

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Show one digit for hold edges, then one blank gap edge.
    task automatic applyStimulus(input logic [3:0] dig, input logic [7:0] seg, input int hold);
        digits   = dig;
        segments = seg;
        step(hold);
        digits   = 4'b0000;
        segments = 8'h00;
        step(1);
    endtask

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
        end
    endtask

    initial begin
        rst_n    = 1'b0;
        en       = 1'b0;
        digits   = 4'b0000;
        segments = 8'h00;
        step(2);
        checkOutput("reset_hexx", 32'(hexx), 32'h0000);
        checkOutput("reset_points", 32'(points), 32'h0);
        checkOutput("reset_valid", 32'(digit_valid), 32'h0);
        checkOutput("reset_flags", {30'd0, frame_done, stale}, 32'h0);
        rst_n = 1'b1;
        en    = 1'b1;

        // Full frame "3","A","b","F" with dp on D1 and D3
        applyStimulus(4'b0001, 8'b1111_0011, 4);
        checkOutput("d1_latency_hexx", 32'(hexx), 32'h0003);
        applyStimulus(4'b0010, 8'b1110_1110, 4);
        applyStimulus(4'b0100, 8'b0011_1111, 4);
        checkOutput("no_early_frame", 32'(frame_done), 32'h0);
        applyStimulus(4'b1000, 8'b1000_1110, 4);
        checkOutput("frame_hexx", 32'(hexx), 32'hFBA3);
        checkOutput("frame_points", 32'(points), 32'h5);
        checkOutput("frame_a2f", 32'(is_a2f), 32'hE);
        checkOutput("frame_invalid", 32'(invalid), 32'h0);
        checkOutput("frame_valid", 32'(digit_valid), 32'hF);
        checkOutput("frame_done_pulse", 32'(frame_done), 32'h1);
        checkOutput("s1_frame_hexx", 32'(hexx1), 32'hFBA3);
        step(1);
        checkOutput("frame_done_clear", 32'(frame_done), 32'h0);

        // Stale: 15 edges after the D4 commit edge
        step(13);
        checkOutput("stale_not_yet", 32'(stale), 32'h0);
        step(1);
        checkOutput("stale_set", 32'(stale), 32'h1);
        checkOutput("stale_valid_clr", 32'(digit_valid), 32'h0);
        checkOutput("stale_hexx_hold", 32'(hexx), 32'hFBA3);

        // D2 "5" held only 3 edges: ignored (the STABLE_CYCLES=1 copy takes it)
        applyStimulus(4'b0010, 8'b1011_0110, 3);
        checkOutput("short_hexx", 32'(hexx), 32'hFBA3);
        checkOutput("short_valid1", 32'(digit_valid[1]), 32'h0);
        checkOutput("short_stale", 32'(stale), 32'h1);
        checkOutput("s1_short_hexx", 32'(hexx1), 32'hFB53);

        // One-edge strobe of "7" on D3
        applyStimulus(4'b0100, 8'b1110_0000, 1);
        checkOutput("strobe_ignored", 32'(hexx), 32'hFBA3);
        checkOutput("s1_strobe_hexx", 32'(hexx1), 32'hF753);

        // Invalid glyph (segment a only) on D1
        applyStimulus(4'b0001, 8'b1000_0000, 4);
        checkOutput("inv_hexx", 32'(hexx), 32'hFBA0);
        checkOutput("inv_flag", 32'(invalid), 32'h1);
        checkOutput("inv_valid", 32'(digit_valid), 32'h1);
        checkOutput("inv_point", 32'(points), 32'h4);
        checkOutput("inv_stale_clr", 32'(stale), 32'h0);
        checkOutput("inv_no_frame", 32'(frame_done), 32'h0);

        // Multi-hot strobes never commit
        digits   = 4'b0011;
        segments = 8'b1111_1110;
        step(10);
        digits   = 4'b0000;
        segments = 8'h00;
        step(1);
        checkOutput("multihot_hexx", 32'(hexx), 32'hFBA0);
        checkOutput("multihot_valid", 32'(digit_valid), 32'h1);
        checkOutput("multihot_stale", 32'(stale), 32'h0);

        // Capture disabled: a long hold does nothing
        en = 1'b0;
        applyStimulus(4'b1000, 8'b0110_0000, 6);
        checkOutput("en0_hexx", 32'(hexx), 32'hFBA0);
        checkOutput("en0_valid", 32'(digit_valid), 32'h1);
        en = 1'b1;

        // Reset in the middle of a D3 "8" hold
        digits   = 4'b0100;
        segments = 8'b1111_1110;
        step(2);
        rst_n = 1'b0;
        step(1);
        checkOutput("rst_mid_hexx", 32'(hexx), 32'h0000);
        checkOutput("rst_mid_invalid", 32'(invalid), 32'h0);
        rst_n = 1'b1;
        step(4);
        checkOutput("rst_fresh_hold", 32'(hexx), 32'h0000);
        checkOutput("rst_fresh_valid0", 32'(digit_valid), 32'h0);
        step(1);
        checkOutput("rst_fresh_hexx", 32'(hexx), 32'h0800);
        checkOutput("rst_fresh_valid", 32'(digit_valid), 32'h4);
        digits   = 4'b0000;
        segments = 8'h00;
        step(2);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
